// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the cpu single-port memory interface.
// Owns a word-addressed backing store. Each request is latched in IDLE and answered
// with a one-cycle mem_resp after a fixed latency. The hold input freezes the countdown.
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous reset, active-low
//   mem_read        read request, held by the initiator until mem_resp
//   mem_write       write request, held by the initiator until mem_resp
//   mem_byte_enable write lane enables, bit i -> data bits [8i+7:8i]
//   mem_address     byte address; low log2(width/8) bits ignored, upper bits alias
//   mem_wdata       write data
//   hold            while 1, freezes the latency countdown
//   mem_resp        one-cycle completion pulse
//   mem_rdata       read data, valid in the mem_resp cycle, holds afterwards
//   mem_err         sticky flag: read and write requested together
module mem_responder #(
   parameter int unsigned width   = 32,
   parameter int unsigned depth   = 256,
   parameter int unsigned latency = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [width/8-1:0]   mem_byte_enable,
   input  logic [width-1:0]     mem_address,
   input  logic [width-1:0]     mem_wdata,
   input  logic                 hold,
   output logic                 mem_resp,
   output logic [width-1:0]     mem_rdata,
   output logic                 mem_err
);

   localparam int unsigned Lanes = width / 8;
   localparam int unsigned OffW  = $clog2(Lanes);
   localparam int unsigned IdxW  = $clog2(depth);
   localparam int unsigned CntW  = (latency > 1) ? $clog2(latency) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                op_write_q, op_write_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [width-1:0]    wdata_q, wdata_d;
   logic [Lanes-1:0]    be_q, be_d;
   logic [width-1:0]    rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [width-1:0]    mem_q [depth];
   logic [IdxW-1:0]     req_idx;

   // Upper address bits beyond the store size simply alias.
   assign req_idx = mem_address[OffW +: IdxW];

   // State and latched-request registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         op_write_q <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_write_q <= op_write_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // Backing store is never cleared. A write commits only at the edge closing RESP, so a
   // reset during BUSY (which forces IDLE) discards the pending write.
   always_ff @(posedge clk) begin
      if (state_q == StResp && op_write_q) begin
         for (int unsigned i = 0; i < Lanes; i++) begin
            if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   // Next-state and datapath.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_write_d = op_write_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      unique case (state_q)
         StIdle: begin
            if (mem_read || mem_write) begin
               // Simultaneous read and write is treated as a write.
               op_write_d = mem_write;
               idx_d      = req_idx;
               wdata_d    = mem_wdata;
               be_d       = mem_byte_enable;
               cnt_d      = CntW'(latency - 1);
               if (mem_read && mem_write) err_d = 1'b1;
               if (latency == 1) begin
                  state_d = StResp;
                  rdata_d = mem_q[req_idx];
               end else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (!hold) begin
               cnt_d = cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_d = StResp;
                  // Store is sampled on the edge entering RESP.
                  rdata_d = mem_q[idx_q];
               end
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      mem_resp  = (state_q == StResp);
      mem_rdata = rdata_q;
      mem_err   = err_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder with a word-array
// reference model and latency expectations computed from the request/hold timeline.
module tb_mem_responder;

   localparam int unsigned Width   = 32;
   localparam int unsigned Depth   = 256;
   localparam int unsigned Latency = 2;

   logic              clk;
   logic              rst;
   logic              mem_read;
   logic              mem_write;
   logic [3:0]        mem_byte_enable;
   logic [Width-1:0]  mem_address;
   logic [Width-1:0]  mem_wdata;
   logic              hold;
   logic              mem_resp;
   logic [Width-1:0]  mem_rdata;
   logic              mem_err;

   mem_responder #(
      .width   (Width),
      .depth   (Depth),
      .latency (Latency)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .hold            (hold),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata),
      .mem_err         (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] model [Depth];
   logic        err_model = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned widx(input logic [31:0] a);
      return (a / 4) % Depth;
   endfunction

   // One complete transaction; reports data seen in the resp cycle and edges to resp.
   task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input int holds,
                      output logic [31:0] rdata, output int lat);
      bit got;
      got   = 0;
      lat   = 0;
      rdata = '0;
      @(negedge clk);
      mem_read = rd; mem_write = wr; mem_address = addr;
      mem_wdata = wd; mem_byte_enable = be; hold = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(posedge clk); #1;
         if (mem_resp) begin
            got   = 1;
            lat   = k;
            rdata = mem_rdata;
         end else begin
            hold = (k <= holds);
         end
      end
      mem_read = 1'b0; mem_write = 1'b0; hold = 1'b0;
      if (!got) check("resp_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      check("resp_width", mem_resp, 1'b0);
   endtask

   // Transaction checked against the model; updates the model for writes.
   task automatic do_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int holds, output logic [31:0] rdata);
      int lat;
      int unsigned i;
      i = widx(addr);
      txn(rd, wr, addr, wd, be, holds, rdata, lat);
      check({tag, "_lat"}, lat, Latency + holds);
      if (wr) begin
         for (int b = 0; b < 4; b++) if (be[b]) model[i][8*b +: 8] = wd[8*b +: 8];
         if (rd) err_model = 1'b1;
      end else begin
         check({tag, "_rdata"}, rdata, model[i]);
      end
      check({tag, "_err"}, mem_err, err_model);
   endtask

   logic [31:0] r;
   int          n;
   int          last;

   initial begin
      rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
      mem_address = '0; mem_wdata = '0; hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_resp", mem_resp, 1'b0);
      check("reset_rdata", mem_rdata, 32'd0);
      check("reset_err", mem_err, 1'b0);
      @(negedge clk); rst = 1'b1;

      // Fill the whole store so every later read has a known expectation.
      for (int i = 0; i < Depth; i++)
         do_op("fill", 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, r);

      // Reset during BUSY discards the pending write.
      @(negedge clk);
      mem_write = 1'b1; mem_address = 32'h10; mem_wdata = 32'hDEADBEEF; mem_byte_enable = 4'hF;
      @(posedge clk); #1;
      check("abort_busy_resp", mem_resp, 1'b0);
      @(negedge clk); rst = 1'b0; #1;
      check("abort_resp", mem_resp, 1'b0);
      check("abort_err", mem_err, 1'b0);
      check("abort_rdata", mem_rdata, 32'd0);
      @(negedge clk); mem_write = 1'b0;
      @(negedge clk); rst = 1'b1;
      do_op("abort_read", 1'b1, 1'b0, 32'h10, 0, 4'h0, 0, r);
      check("abort_not_committed", (r == 32'hDEADBEEF), 1'b0);

      // Full write then read.
      do_op("full_wr", 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, r);
      do_op("full_rd", 1'b1, 1'b0, 32'h40, 0, 4'h0, 0, r);
      check("full_rd_const", r, 32'h12345678);

      // Partial lanes and empty byte enable.
      do_op("pre_wr", 1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF, 0, r);
      do_op("part_wr", 1'b0, 1'b1, 32'h8, 32'h11223344, 4'b0101, 0, r);
      do_op("part_rd", 1'b1, 1'b0, 32'h8, 0, 4'h0, 0, r);
      check("part_rd_const", r, 32'hAA22CC44);
      do_op("be0_wr", 1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 0, r);
      do_op("be0_rd", 1'b1, 1'b0, 32'h8, 0, 4'h0, 0, r);
      check("be0_rd_const", r, 32'hAA22CC44);

      // Hold for 3 cycles during BUSY.
      do_op("hold3", 1'b1, 1'b0, 32'h40, 0, 4'h0, 3, r);

      // Continuous read request: pulses latency+1 apart.
      @(negedge clk);
      mem_read = 1'b1; mem_address = 32'h40;
      n = 0; last = 0;
      for (int k = 1; k <= 30 && n < 3; k++) begin
         @(posedge clk); #1;
         if (mem_resp) begin
            check("b2b_rdata", mem_rdata, model[widx(32'h40)]);
            if (n == 0) check("b2b_first", k, Latency);
            else check("b2b_gap", k - last, Latency + 1);
            last = k;
            n++;
            if (n == 3) mem_read = 1'b0;
         end
      end
      mem_read = 1'b0;
      check("b2b_count", n, 3);
      @(posedge clk); #1;
      check("b2b_width", mem_resp, 1'b0);

      // Aliasing and ignored low address bits.
      do_op("alias_wr", 1'b0, 1'b1, 32'h004, 32'hCAFEF00D, 4'hF, 0, r);
      do_op("alias_rd_hi", 1'b1, 1'b0, 32'h406, 0, 4'h0, 0, r);
      check("alias_hi_const", r, 32'hCAFEF00D);
      do_op("alias_rd_lo", 1'b1, 1'b0, 32'h004, 0, 4'h0, 0, r);
      check("alias_lo_const", r, 32'hCAFEF00D);

      // Randomized traffic.
      for (int t = 0; t < 120; t++) begin
         if ($urandom_range(1, 0) == 1)
            do_op("rnd_wr", 1'b0, 1'b1, $urandom, $urandom, 4'($urandom_range(15, 0)),
                  $urandom_range(3, 0), r);
         else
            do_op("rnd_rd", 1'b1, 1'b0, $urandom, 0, 4'($urandom_range(15, 0)),
                  $urandom_range(3, 0), r);
      end

      // Protocol error: both requests at once act as a write and set a sticky flag.
      check("err_before", mem_err, 1'b0);
      do_op("both", 1'b1, 1'b1, 32'h20, 32'h5, 4'hF, 0, r);
      check("err_set", mem_err, 1'b1);
      do_op("both_rd", 1'b1, 1'b0, 32'h20, 0, 4'h0, 0, r);
      check("both_rd_const", r, 32'h5);
      check("err_sticky", mem_err, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
